// File: rtl/deser_pkg.sv
// Shared types and sizing helpers for the serial word deserializer.
package deser_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY
    } deser_state_t;

    function automatic int unsigned COUNT_W(input int unsigned width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/deser_hold_reg.sv
// One-entry valid/ready holding register for completed words, with sticky overrun.
module deser_hold_reg #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_perr,
    input  logic             out_ready,
    input  logic             clr_err,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    output logic             out_perr,
    output logic             overrun
);

    logic can_load;
    logic drop;

    // A full register can still take a new word if it is being drained this cycle.
    assign can_load = !out_valid || out_ready;
    assign drop     = load && !can_load;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data  <= '0;
            out_perr  <= 1'b0;
            out_valid <= 1'b0;
        end else if (load && can_load) begin
            out_data  <= load_data;
            out_perr  <= load_perr;
            out_valid <= 1'b1;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overrun <= 1'b0;
        end else if (drop) begin
            overrun <= 1'b1;
        end else if (clr_err) begin
            overrun <= 1'b0;
        end
    end

endmodule

// File: rtl/serial_word_deserializer.sv
// Receive side of the bit-serial link: assembles MSB-first serial bits into
// WIDTH-bit words with optional parity and hands them to a valid/ready consumer.
module serial_word_deserializer
    import deser_pkg::*;
#(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned PARITY_EN  = 1,
    parameter int unsigned PARITY_ODD = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_bit,
    input  logic             in_sof,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_perr,
    output logic             overrun,
    input  logic             clr_err,
    output logic             busy
);

    localparam int unsigned    CW        = COUNT_W(WIDTH);
    localparam logic [CW-1:0]  LAST_DATA = CW'(WIDTH - 1);
    localparam logic           PAR       = (PARITY_EN != 0);
    localparam logic           ODD       = (PARITY_ODD != 0);

    deser_state_t     state;
    deser_state_t     state_nx;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] shifted;
    logic             last_data;

    logic             done;
    logic [WIDTH-1:0] done_word;
    logic             done_pbit;
    logic             done_perr;

    assign shifted   = {sr[WIDTH-2:0], in_bit};
    assign last_data = (count == LAST_DATA);
    assign busy      = (count != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        if (in_valid) begin
            case (state)
                IDLE: begin
                    if (in_sof) state_nx = DATA;
                end
                DATA: begin
                    if (!in_sof && last_data && PAR) state_nx = PARITY;
                end
                PARITY: begin
                    state_nx = DATA;
                end
                default: begin
                    state_nx = IDLE;
                end
            endcase
        end
    end

    // A start-of-frame bit always preempts completion: the partial word is abandoned.
    always_comb begin
        done      = 1'b0;
        done_word = shifted;
        done_pbit = 1'b0;
        if (in_valid && !in_sof) begin
            case (state)
                DATA: begin
                    if (last_data && !PAR) done = 1'b1;
                end
                PARITY: begin
                    done      = 1'b1;
                    done_word = sr;
                    done_pbit = in_bit;
                end
                default: begin
                    done = 1'b0;
                end
            endcase
        end
    end

    assign done_perr = PAR ? (((^done_word) ^ done_pbit) != ODD) : 1'b0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr    <= '0;
            count <= '0;
        end else if (in_valid) begin
            if (in_sof) begin
                sr    <= {{(WIDTH-1){1'b0}}, in_bit};
                count <= CW'(1);
            end else if (state == DATA) begin
                sr    <= shifted;
                count <= (last_data && !PAR) ? '0 : count + CW'(1);
            end else if (state == PARITY) begin
                count <= '0;
            end
        end
    end

    deser_hold_reg #(
        .WIDTH(WIDTH)
    ) u_hold (
        .clk      (clk),
        .rst      (rst),
        .load     (done),
        .load_data(done_word),
        .load_perr(done_perr),
        .out_ready(out_ready),
        .clr_err  (clr_err),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_perr (out_perr),
        .overrun  (overrun)
    );

endmodule

// File: tb/tb_serial_word_deserializer.sv
// Directed bench: one deserializer without parity (dut0) and one with even parity (dut1).
module tb_serial_word_deserializer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       v0 = 1'b0;
    logic       v1 = 1'b0;
    logic       in_bit = 1'b0;
    logic       in_sof = 1'b0;
    logic       out_ready = 1'b1;
    logic       clr_err = 1'b0;

    logic [7:0] od0, od1;
    logic       ov0, ov1, operr0, operr1, ovr0, ovr1, busy0, busy1;

    logic [8:0] q0[$];
    logic [8:0] q1[$];
    logic [8:0] exp_w;
    int         total = 0;
    int         bad = 0;

    always #5 clk = ~clk;

    serial_word_deserializer #(.WIDTH(8), .PARITY_EN(0), .PARITY_ODD(0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(v0), .in_bit(in_bit), .in_sof(in_sof),
        .out_data(od0), .out_valid(ov0), .out_ready(out_ready), .out_perr(operr0),
        .overrun(ovr0), .clr_err(clr_err), .busy(busy0)
    );

    serial_word_deserializer #(.WIDTH(8), .PARITY_EN(1), .PARITY_ODD(0)) dut1 (
        .clk(clk), .rst(rst), .in_valid(v1), .in_bit(in_bit), .in_sof(in_sof),
        .out_data(od1), .out_valid(ov1), .out_ready(out_ready), .out_perr(operr1),
        .overrun(ovr1), .clr_err(clr_err), .busy(busy1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard side: a handshake seen at the negedge is consumed on the next posedge.
    task automatic tick();
        @(negedge clk);
        if (!rst && ov0 && out_ready) begin
            total++;
            assert (q0.size() != 0) else begin
                bad++;
                $error("FAIL dut0_unexpected_word observed=%0h expected=none", od0);
            end
            if (q0.size() != 0) begin
                exp_w = q0.pop_front();
                chk("dut0_word", {23'd0, operr0, od0}, {23'd0, exp_w});
            end
        end
        if (!rst && ov1 && out_ready) begin
            total++;
            assert (q1.size() != 0) else begin
                bad++;
                $error("FAIL dut1_unexpected_word observed=%0h expected=none", od1);
            end
            if (q1.size() != 0) begin
                exp_w = q1.pop_front();
                chk("dut1_word", {23'd0, operr1, od1}, {23'd0, exp_w});
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input int sel, input logic b, input logic sof, input logic rdy_now);
        repeat ($urandom_range(0, 2)) begin
            v0 = 1'b0;
            v1 = 1'b0;
            in_bit = 1'($urandom);
            in_sof = 1'($urandom);
            tick();
        end
        if (rdy_now) out_ready = 1'b1;
        in_bit = b;
        in_sof = sof;
        v0 = (sel == 0);
        v1 = (sel == 1);
        tick();
        v0 = 1'b0;
        v1 = 1'b0;
        in_sof = 1'b0;
    endtask

    task automatic send_word(input int sel, input logic [7:0] d, input logic sof,
                             input logic has_par, input logic pbit, input logic rdy_last);
        for (int i = 7; i >= 0; i--) begin
            send_bit(sel, d[i], sof && (i == 7), rdy_last && !has_par && (i == 0));
        end
        if (has_par) send_bit(sel, pbit, 1'b0, rdy_last);
    endtask

    initial begin
        // reset state
        repeat (2) tick();
        chk("rst_valid0", {31'd0, ov0}, 0);
        chk("rst_data1", {24'd0, od1}, 0);
        chk("rst_flags1", {28'd0, ov1, operr1, ovr1, busy1}, 0);
        rst = 1'b0;
        tick();

        // 1: no-parity word A5, latency check, then back-to-back without sof
        q0.push_back({1'b0, 8'hA5});
        send_bit(0, 1'b1, 1'b1, 1'b0);
        send_bit(0, 1'b0, 1'b0, 1'b0);
        send_bit(0, 1'b1, 1'b0, 1'b0);
        send_bit(0, 1'b0, 1'b0, 1'b0);
        send_bit(0, 1'b0, 1'b0, 1'b0);
        send_bit(0, 1'b1, 1'b0, 1'b0);
        send_bit(0, 1'b0, 1'b0, 1'b0);
        chk("t1_pre_busy_valid", {30'd0, busy0, ov0}, 32'h2);
        send_bit(0, 1'b1, 1'b0, 1'b0);
        chk("t1_post_valid_busy", {30'd0, ov0, busy0}, 32'h2);
        chk("t1_data", {24'd0, od0}, 32'hA5);
        q0.push_back({1'b0, 8'h3E});
        send_word(0, 8'h3E, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) tick();

        // 2: even parity good and bad
        q1.push_back({1'b0, 8'h0F});
        send_word(1, 8'h0F, 1'b1, 1'b1, 1'b0, 1'b0);
        q1.push_back({1'b1, 8'h0F});
        send_word(1, 8'h0F, 1'b0, 1'b1, 1'b1, 1'b0);
        repeat (2) tick();

        // 3: stalled consumer, second word dropped, overrun then clear
        out_ready = 1'b0;
        q1.push_back({1'b0, 8'h11});
        send_word(1, 8'h11, 1'b1, 1'b1, 1'b0, 1'b0);
        send_word(1, 8'h22, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        chk("t3_hold_data", {24'd0, od1}, 32'h11);
        chk("t3_valid_overrun", {30'd0, ov1, ovr1}, 32'h3);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        chk("t3_overrun_cleared", {31'd0, ovr1}, 0);
        out_ready = 1'b1;
        repeat (2) tick();
        chk("t3_valid_drained", {31'd0, ov1}, 0);

        // 4: sof aborts a partial word
        send_bit(1, 1'b1, 1'b1, 1'b0);
        send_bit(1, 1'b1, 1'b0, 1'b0);
        send_bit(1, 1'b1, 1'b0, 1'b0);
        q1.push_back({1'b0, 8'h3C});
        send_word(1, 8'h3C, 1'b1, 1'b1, 1'b0, 1'b0);
        repeat (2) tick();
        chk("t4_overrun", {31'd0, ovr1}, 0);

        // 5: completion coincides with acceptance of the held word
        out_ready = 1'b0;
        q1.push_back({1'b0, 8'h5A});
        send_word(1, 8'h5A, 1'b1, 1'b1, 1'b0, 1'b0);
        q1.push_back({1'b0, 8'hC3});
        send_word(1, 8'hC3, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("t5_reload", {22'd0, ov1, ovr1, od1}, {22'd0, 2'b10, 8'hC3});
        repeat (2) tick();

        // 6: reset with held word, overrun set and a partial word in progress
        out_ready = 1'b0;
        send_word(1, 8'h77, 1'b1, 1'b1, 1'b0, 1'b0);
        send_word(1, 8'h12, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) send_bit(1, 1'(i), i == 0, 1'b0);
        chk("t6_pre_flags", {29'd0, ov1, ovr1, busy1}, 32'h7);
        rst = 1'b1;
        #1;
        chk("t6_rst_data", {24'd0, od1}, 0);
        chk("t6_rst_flags", {28'd0, ov1, operr1, ovr1, busy1}, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        q1.push_back({1'b0, 8'h96});
        send_word(1, 8'h96, 1'b1, 1'b1, 1'b0, 1'b0);

        repeat (4) tick();
        chk("q0_drained", q0.size(), 0);
        chk("q1_drained", q1.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
